// File: rtl/riscv_decode_pkg.sv
// Shared constants for the RV32I decoder: opcodes, ALU operation codes and
// operand-A select encodings.
package riscv_decode_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b001000;
  localparam logic [5:0] ALU_SLL    = 6'b000001;
  localparam logic [5:0] ALU_SLT    = 6'b000010;
  localparam logic [5:0] ALU_SLTU   = 6'b000011;
  localparam logic [5:0] ALU_XOR    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_SRA    = 6'b001101;
  localparam logic [5:0] ALU_OR     = 6'b000110;
  localparam logic [5:0] ALU_AND    = 6'b000111;
  localparam logic [5:0] ALU_BEQ    = 6'b010000;
  localparam logic [5:0] ALU_BNE    = 6'b010001;
  localparam logic [5:0] ALU_BLT    = 6'b010100;
  localparam logic [5:0] ALU_BGE    = 6'b010101;
  localparam logic [5:0] ALU_BLTU   = 6'b010110;
  localparam logic [5:0] ALU_BGEU   = 6'b010111;
  localparam logic [5:0] ALU_PASS_A = 6'b011111;

  // Operand A source
  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_PC4  = 2'b10,
    OPA_ZERO = 2'b11
  } opa_sel_e;

  // True when funct3 names a real operation for opcodes that restrict it.
  // Opcodes without restrictions (R-type, I-ALU, JAL, LUI, AUIPC) return 1.
  function automatic logic funct3_legal(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    logic ok;
    ok = 1'b1;
    case (opcode)
      OPC_LOAD:   ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_STORE:  ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OPC_BRANCH: ok = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_JALR:   ok = (funct3 == 3'b000);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_decode_imm_gen.sv
// Immediate generator: selects the immediate format from the opcode and
// produces the 32-bit (sign- or zero-extended) immediate.
module riscv_imm_gen
  import riscv_decode_pkg::*;
(
  input  logic [31:0] instruction_i,
  output logic [31:0] imm32_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];

  // Format selection; shift-immediates carry an unsigned shamt, R-type and
  // unknown opcodes have no immediate.
  always_comb begin
    imm32_o = 32'd0;
    case (opcode)
      OPC_IALU: begin
        if ((funct3 == 3'b001) || (funct3 == 3'b101))
          imm32_o = {27'd0, instruction_i[24:20]};
        else
          imm32_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm32_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
      OPC_STORE:
        imm32_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      OPC_BRANCH:
        imm32_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                   instruction_i[30:25], instruction_i[11:8], 1'b0};
      OPC_JAL:
        imm32_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                   instruction_i[20], instruction_i[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32_o = {instruction_i[31:12], 12'd0};
      default:
        imm32_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_decode.sv
// RV32I single-cycle instruction decoder: register selects, control signals,
// immediate, ALU operation and next-PC resolution. Fully combinational; reset
// only suppresses the outputs that change architectural state or flow.
module riscv_decode
  import riscv_decode_pkg::*;
#(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    branch,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic [31:0]             imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    wb_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       legal;

  logic       wen_d;
  logic       mwe_d;
  logic       bop_d;
  logic       nps_d;
  logic       use_jalr;
  opa_sel_e   opa_d;
  logic       opb_d;
  logic [5:0] alu_d;
  logic       wb_d;

  // No state is clocked; the clock exists only for interface uniformity.
  logic unused_clock;
  assign unused_clock = clock;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign alt    = instruction[30];
  assign legal  = funct3_legal(opcode, funct3);

  // Register selects are the raw fields whatever the format.
  assign read_sel1 = instruction[19:15];
  assign read_sel2 = instruction[24:20];
  assign write_sel = instruction[11:7];

  riscv_imm_gen u_imm_gen (
    .instruction_i (instruction),
    .imm32_o       (imm32)
  );

  // Control decode; safe defaults leave unknown encodings as a harmless ADD.
  always_comb begin
    wen_d    = 1'b0;
    mwe_d    = 1'b0;
    bop_d    = 1'b0;
    nps_d    = 1'b0;
    use_jalr = 1'b0;
    opa_d    = OPA_RS1;
    opb_d    = 1'b0;
    alu_d    = ALU_ADD;
    wb_d     = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        wen_d = 1'b1;
        alu_d = {2'b00, ((funct3 == 3'b000) || (funct3 == 3'b101)) ? alt : 1'b0, funct3};
      end
      OPC_IALU: begin
        wen_d = 1'b1;
        opb_d = 1'b1;
        alu_d = {2'b00, (funct3 == 3'b101) ? alt : 1'b0, funct3};
      end
      OPC_LOAD: begin
        opb_d = 1'b1;
        wen_d = legal;
        wb_d  = legal;
      end
      OPC_STORE: begin
        opb_d = 1'b1;
        mwe_d = legal;
      end
      OPC_BRANCH: begin
        if (legal) begin
          bop_d = 1'b1;
          alu_d = {3'b010, funct3};
          nps_d = branch;
        end
      end
      OPC_JAL: begin
        opa_d = OPA_PC4;
        alu_d = ALU_PASS_A;
        wen_d = 1'b1;
        nps_d = 1'b1;
      end
      OPC_JALR: begin
        if (legal) begin
          opa_d    = OPA_PC4;
          alu_d    = ALU_PASS_A;
          wen_d    = 1'b1;
          nps_d    = 1'b1;
          use_jalr = 1'b1;
        end
      end
      OPC_LUI: begin
        opa_d = OPA_ZERO;
        opb_d = 1'b1;
        wen_d = 1'b1;
      end
      OPC_AUIPC: begin
        opa_d = OPA_PC;
        opb_d = 1'b1;
        wen_d = 1'b1;
      end
      default: begin
        alu_d = ALU_ADD;
      end
    endcase
  end

  // Reset blocks every output that would write state or redirect fetch.
  assign wEn            = wen_d & ~reset;
  assign mem_wEn        = mwe_d & ~reset;
  assign branch_op      = bop_d & ~reset;
  assign next_PC_select = nps_d & ~reset;

  assign op_A_sel    = opa_d;
  assign op_B_sel    = opb_d;
  assign ALU_Control = alu_d;
  assign wb_sel      = wb_d;

  // PC-relative target wraps modulo 2^ADDRESS_BITS.
  assign target_PC = use_jalr ? JALR_target : (PC + imm32[ADDRESS_BITS-1:0]);

endmodule

// File: tb/tb_riscv_decode.sv
// Scoreboard bench for riscv_decode: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry per cycle.
module tb_riscv_decode;

  logic        clock;
  logic        reset;
  logic [15:0] PC;
  logic [31:0] instruction;
  logic [15:0] JALR_target;
  logic        branch;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic [4:0]  read_sel1;
  logic [4:0]  read_sel2;
  logic [4:0]  write_sel;
  logic        wEn;
  logic        branch_op;
  logic [31:0] imm32;
  logic [1:0]  op_A_sel;
  logic        op_B_sel;
  logic [5:0]  ALU_Control;
  logic        mem_wEn;
  logic        wb_sel;

  riscv_decode #(.ADDRESS_BITS(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .instruction    (instruction),
    .JALR_target    (JALR_target),
    .branch         (branch),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .read_sel1      (read_sel1),
    .read_sel2      (read_sel2),
    .write_sel      (write_sel),
    .wEn            (wEn),
    .branch_op      (branch_op),
    .imm32          (imm32),
    .op_A_sel       (op_A_sel),
    .op_B_sel       (op_B_sel),
    .ALU_Control    (ALU_Control),
    .mem_wEn        (mem_wEn),
    .wb_sel         (wb_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        nps;
    logic [15:0] tpc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        bop;
    logic [31:0] imm;
    logic [1:0]  opa;
    logic        opb;
    logic [5:0]  alu;
    logic        mwe;
    logic        wb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: the decoder answers within the cycle, so one entry per edge.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "next_PC_select", 32'(next_PC_select), 32'(e.nps));
      chk(e.nm, "target_PC",      32'(target_PC),      32'(e.tpc));
      chk(e.nm, "read_sel1",      32'(read_sel1),      32'(e.rs1));
      chk(e.nm, "read_sel2",      32'(read_sel2),      32'(e.rs2));
      chk(e.nm, "write_sel",      32'(write_sel),      32'(e.rd));
      chk(e.nm, "wEn",            32'(wEn),            32'(e.wen));
      chk(e.nm, "branch_op",      32'(branch_op),      32'(e.bop));
      chk(e.nm, "imm32",          imm32,               e.imm);
      chk(e.nm, "op_A_sel",       32'(op_A_sel),       32'(e.opa));
      chk(e.nm, "op_B_sel",       32'(op_B_sel),       32'(e.opb));
      chk(e.nm, "ALU_Control",    32'(ALU_Control),    32'(e.alu));
      chk(e.nm, "mem_wEn",        32'(mem_wEn),        32'(e.mwe));
      chk(e.nm, "wb_sel",         32'(wb_sel),         32'(e.wb));
    end
  end

  task automatic vec(input string nm, input logic r, input logic [15:0] pc,
                     input logic [15:0] jt, input logic [31:0] ins, input logic br,
                     input logic nps, input logic [15:0] tpc,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic wen, input logic bop, input logic [31:0] imm,
                     input logic [1:0] opa, input logic opb, input logic [5:0] alu,
                     input logic mwe, input logic wb);
    exp_t e;
    @(negedge clock);
    reset       = r;
    PC          = pc;
    JALR_target = jt;
    instruction = ins;
    branch      = br;
    e.nm = nm;  e.nps = nps; e.tpc = tpc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.wen = wen; e.bop = bop; e.imm = imm; e.opa = opa; e.opb = opb; e.alu = alu;
    e.mwe = mwe; e.wb = wb;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; PC = '0; JALR_target = '0; instruction = '0; branch = 1'b0;
    //   name        rst pc       jt       instr         br  nps tpc      rs1 rs2 rd wen bop imm           opa    opb alu        mwe wb
    vec("addi_rst",  1, 16'h0000, 16'h0000, 32'hFFF00593, 0,  0, 16'hFFFF, 0,  31, 11, 0, 0, 32'hFFFFFFFF, 2'b00, 1, 6'b000000, 0, 0);
    vec("addi",      0, 16'h0000, 16'h0000, 32'hFFF00593, 0,  0, 16'hFFFF, 0,  31, 11, 1, 0, 32'hFFFFFFFF, 2'b00, 1, 6'b000000, 0, 0);
    vec("sub",       0, 16'h0200, 16'h0000, 32'h40E608B3, 0,  0, 16'h0200, 12, 14, 17, 1, 0, 32'h00000000, 2'b00, 0, 6'b001000, 0, 0);
    vec("srai",      0, 16'h0000, 16'h0000, 32'h4055D593, 0,  0, 16'h0005, 11, 5,  11, 1, 0, 32'h00000005, 2'b00, 1, 6'b001101, 0, 0);
    vec("addi_b30",  0, 16'h0000, 16'h0000, 32'h40000513, 0,  0, 16'h0400, 0,  0,  10, 1, 0, 32'h00000400, 2'b00, 1, 6'b000000, 0, 0);
    vec("sw",        0, 16'h0000, 16'h0000, 32'h00C5A023, 0,  0, 16'h0000, 11, 12, 0,  0, 0, 32'h00000000, 2'b00, 1, 6'b000000, 1, 0);
    vec("sw_rst",    1, 16'h0000, 16'h0000, 32'h00C5A023, 0,  0, 16'h0000, 11, 12, 0,  0, 0, 32'h00000000, 2'b00, 1, 6'b000000, 0, 0);
    vec("lw",        0, 16'h0000, 16'h0000, 32'h0005A903, 0,  0, 16'h0000, 11, 0,  18, 1, 0, 32'h00000000, 2'b00, 1, 6'b000000, 0, 1);
    vec("jal",       0, 16'h0114, 16'h0000, 32'h0140006F, 0,  1, 16'h0128, 0,  20, 0,  1, 0, 32'h00000014, 2'b10, 0, 6'b011111, 0, 0);
    vec("jal_wrap",  0, 16'hFFF0, 16'h0000, 32'h0140006F, 0,  1, 16'h0004, 0,  20, 0,  1, 0, 32'h00000014, 2'b10, 0, 6'b011111, 0, 0);
    vec("jalr",      0, 16'h0094, 16'h0154, 32'h0C4080E7, 0,  1, 16'h0154, 1,  4,  1,  1, 0, 32'h000000C4, 2'b10, 0, 6'b011111, 0, 0);
    vec("bgeu_t",    0, 16'h0094, 16'h0000, 32'hFEC5FEE3, 1,  1, 16'h0090, 11, 12, 29, 0, 1, 32'hFFFFFFFC, 2'b00, 0, 6'b010111, 0, 0);
    vec("bgeu_nt",   0, 16'h0094, 16'h0000, 32'hFEC5FEE3, 0,  0, 16'h0090, 11, 12, 29, 0, 1, 32'hFFFFFFFC, 2'b00, 0, 6'b010111, 0, 0);
    vec("bgeu_rst",  1, 16'h0094, 16'h0000, 32'hFEC5FEE3, 1,  0, 16'h0090, 11, 12, 29, 0, 0, 32'hFFFFFFFC, 2'b00, 0, 6'b010111, 0, 0);
    vec("br_badf3",  0, 16'h0094, 16'h0000, 32'hFEC5AEE3, 1,  0, 16'h0090, 11, 12, 29, 0, 0, 32'hFFFFFFFC, 2'b00, 0, 6'b000000, 0, 0);
    vec("lui",       0, 16'h0000, 16'h0000, 32'h0000C5B7, 0,  0, 16'hC000, 1,  0,  11, 1, 0, 32'h0000C000, 2'b11, 1, 6'b000000, 0, 0);
    vec("auipc",     0, 16'h0010, 16'h0000, 32'h00001597, 0,  0, 16'h1010, 0,  0,  11, 1, 0, 32'h00001000, 2'b01, 1, 6'b000000, 0, 0);
    vec("bad_opc",   0, 16'h0040, 16'h0000, 32'h0000007F, 1,  0, 16'h0040, 0,  0,  0,  0, 0, 32'h00000000, 2'b00, 0, 6'b000000, 0, 0);
    // Let the monitor drain the last entries, bounded.
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
